// File: rtl/ray_core_scheduler_if.sv
// ray_core_scheduler_if: core dispatch/collect handshakes and framebuffer write port of the ray-marcher scheduler.
interface ray_core_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int COLOR_WIDTH = 4
);
  localparam int HW = $clog2(H_RES);
  localparam int VW = $clog2(V_RES);
  localparam int AW = $clog2(H_RES * V_RES);
  logic [NUM_CORES-1:0] core_ready_in;
  logic [NUM_CORES-1:0] core_start_out;
  logic [HW-1:0] core_hcount_out;
  logic [VW-1:0] core_vcount_out;
  logic [NUM_CORES-1:0] core_valid_in;
  logic [NUM_CORES*COLOR_WIDTH-1:0] core_color_in;
  logic [NUM_CORES-1:0] core_ack_out;
  logic fb_we_out;
  logic [AW-1:0] fb_addr_out;
  logic [COLOR_WIDTH-1:0] fb_data_out;
  modport master (
    input core_ready_in, core_valid_in, core_color_in,
    output core_start_out, core_hcount_out, core_vcount_out, core_ack_out, fb_we_out, fb_addr_out, fb_data_out
  );
  modport slave (
    output core_ready_in, core_valid_in, core_color_in,
    input core_start_out, core_hcount_out, core_vcount_out, core_ack_out, fb_we_out, fb_addr_out, fb_data_out
  );
endinterface

// File: rtl/ray_core_scheduler.sv
// ray_core_scheduler: raster-order pixel dispatcher plus round-robin framebuffer write arbiter for NUM_CORES marcher cores.
// Defining RAY_SCHED_PERF_CNT_EN adds frame_cycles_out, the busy-cycle count of the last completed frame.
module ray_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int COLOR_WIDTH = 4
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic frame_start_in,
  output logic busy_out,
  output logic frame_done_out,
`ifdef RAY_SCHED_PERF_CNT_EN
  output logic [31:0] frame_cycles_out,
`endif
  ray_core_scheduler_if.master bus
);
  localparam int HW = $clog2(H_RES);
  localparam int VW = $clog2(V_RES);
  localparam int AW = $clog2(H_RES * V_RES);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] x_q, x_d, hc_q, hc_d;
  logic [VW-1:0] y_q, y_d, vc_q, vc_d;
  logic [NUM_CORES-1:0] out_q, out_d, elig, cand, start, ack;
  logic [IW-1:0] dptr_q, dptr_d, cptr_q, cptr_d, dsel, csel;
  logic [AW-1:0] tag_q [NUM_CORES];
  logic [AW-1:0] tag_d [NUM_CORES];
  logic [AW-1:0] addr_q, addr_d, pix_addr;
  logic [COLOR_WIDTH-1:0] data_q, data_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic dgnt, cgnt, last_px, last_row;
`ifdef RAY_SCHED_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d, perf_q, perf_d;
`endif
  // Pointers hold the index that gets first priority next, i.e. one past the last grant.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % NUM_CORES);
  endfunction
  always_comb begin
    elig = state_q == DISPATCH ? bus.core_ready_in & ~out_q : '0;
    cand = bus.core_valid_in & out_q;
    dgnt = 1'b0;
    dsel = dptr_q;
    cgnt = 1'b0;
    csel = cptr_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!dgnt && elig[rr_idx(dptr_q, k)]) begin
        dgnt = 1'b1;
        dsel = rr_idx(dptr_q, k);
      end
      if (!cgnt && cand[rr_idx(cptr_q, k)]) begin
        cgnt = 1'b1;
        csel = rr_idx(cptr_q, k);
      end
    end
    start = dgnt ? NUM_CORES'(1) << dsel : '0;
    ack = cgnt ? NUM_CORES'(1) << csel : '0;
    hc_d = dgnt ? x_q : hc_q;
    vc_d = dgnt ? y_q : vc_q;
    pix_addr = AW'(y_q) * AW'(H_RES) + AW'(x_q);
    out_d = (out_q & ~ack) | start;
    tag_d = tag_q;
    if (dgnt) tag_d[dsel] = pix_addr;
    dptr_d = dgnt ? rr_idx(dsel, 1) : dptr_q;
    cptr_d = cgnt ? rr_idx(csel, 1) : cptr_q;
    we_d = cgnt;
    addr_d = cgnt ? tag_q[csel] : addr_q;
    data_d = cgnt ? bus.core_color_in[csel*COLOR_WIDTH +: COLOR_WIDTH] : data_q;
    last_px = x_q == HW'(H_RES - 1);
    last_row = y_q == VW'(V_RES - 1);
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (frame_start_in) begin
        state_d = DISPATCH;
        busy_d = 1'b1;
        x_d = '0;
        y_d = '0;
      end
      DISPATCH: if (dgnt) begin
        x_d = last_px ? '0 : x_q + 1'b1;
        y_d = last_px ? (last_row ? '0 : y_q + 1'b1) : y_q;
        state_d = last_px && last_row ? DRAIN : DISPATCH;
      end
      // Final result is on the write port exactly when nothing remains outstanding and a write is live.
      DRAIN: if (out_q == '0 && we_q) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef RAY_SCHED_PERF_CNT_EN
    cnt_d = state_q == IDLE && frame_start_in ? '0 : busy_q && cnt_q != '1 ? cnt_q + 32'd1 : cnt_q;
    perf_d = done_d ? cnt_d : perf_q;
`endif
  end
  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      hc_q <= '0;
      vc_q <= '0;
      out_q <= '0;
      dptr_q <= '0;
      cptr_q <= '0;
      tag_q <= '{default: '0};
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef RAY_SCHED_PERF_CNT_EN
      cnt_q <= '0;
      perf_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      hc_q <= hc_d;
      vc_q <= vc_d;
      out_q <= out_d;
      dptr_q <= dptr_d;
      cptr_q <= cptr_d;
      tag_q <= tag_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef RAY_SCHED_PERF_CNT_EN
      cnt_q <= cnt_d;
      perf_q <= perf_d;
`endif
    end
  end
  assign busy_out = busy_q;
  assign frame_done_out = done_q;
  assign bus.core_start_out = start;
  assign bus.core_ack_out = ack;
  assign bus.core_hcount_out = hc_d;
  assign bus.core_vcount_out = vc_d;
  assign bus.fb_we_out = we_q;
  assign bus.fb_addr_out = addr_q;
  assign bus.fb_data_out = data_q;
`ifdef RAY_SCHED_PERF_CNT_EN
  assign frame_cycles_out = perf_q;
`endif
endmodule

// File: tb/tb_ray_core_scheduler.sv
// tb_ray_core_scheduler: emulated marcher cores with random latency/readiness against a frame-level reference model.
module tb_ray_core_scheduler;
  localparam int NC = 2, H = 4, V = 2, CW = 4, NPIX = H * V;
  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
  logic busy, done;
`ifdef RAY_SCHED_PERF_CNT_EN
  logic [31:0] fcyc;
`endif
  ray_core_scheduler_if #(.NUM_CORES(NC), .H_RES(H), .V_RES(V), .COLOR_WIDTH(CW)) bus ();
  ray_core_scheduler #(.NUM_CORES(NC), .H_RES(H), .V_RES(V), .COLOR_WIDTH(CW)) dut (
    .clk_100mhz(clk),
    .rst_n(rst_n),
    .frame_start_in(frame_start),
    .busy_out(busy),
    .frame_done_out(done),
`ifdef RAY_SCHED_PERF_CNT_EN
    .frame_cycles_out(fcyc),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit m_ok, m_busy, m_disp, m_done, m_we, m_rst;
  int m_pix, m_dptr, m_cptr, m_addr, m_h, m_v, busy_cyc;
  logic [31:0] m_perf;
  logic [NC-1:0] m_out;
  int m_tag [NC];
  bit c_job [NC];
  int c_at [NC];
  logic [CW-1:0] c_col [NC];
  int lat_fix [NC];
  bit ready_en [NC];
  bit rnd_ready = 1'b0;
  int cyc = 0, done_cnt = 0, disp_cnt = 0;
  int wr_cnt [NPIX];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int rr_pick(input logic [NC-1:0] req, input int p);
    logic [NC-1:0] s;
    for (int k = 0; k < NC; k++) begin
      s = req >> ((p + k) % NC);
      if (s[0]) return (p + k) % NC;
    end
    return -1;
  endfunction
  function automatic logic [NC-1:0] onehot(input int i);
    return i < 0 ? '0 : NC'(1) << i;
  endfunction
  task automatic model_reset();
    m_ok = 1; m_busy = 0; m_disp = 0; m_done = 0; m_we = 0; m_rst = 1;
    m_pix = 0; m_dptr = 0; m_cptr = 0; m_addr = 0; m_h = 0; m_v = 0;
    m_out = '0; m_perf = '0; busy_cyc = 0;
    foreach (m_tag[i]) m_tag[i] = 0;
  endtask
  // One clock: check outputs mid-cycle, advance cores and model, then drive next-cycle inputs.
  task automatic step();
    int s, a;
    bit fin, was_busy;
    @(negedge clk);
    s = rr_pick(m_disp ? bus.core_ready_in & ~m_out : '0, m_dptr);
    a = rr_pick(bus.core_valid_in & m_out, m_cptr);
    if (s >= 0) begin
      m_h = m_pix % H;
      m_v = m_pix / H;
    end
    if (m_ok) begin
      chk("busy_out", busy, m_busy);
      chk("frame_done_out", done, m_done);
      chk("core_start_out", bus.core_start_out, onehot(s));
      chk("core_hcount_out", bus.core_hcount_out, m_h);
      chk("core_vcount_out", bus.core_vcount_out, m_v);
      chk("core_ack_out", bus.core_ack_out, onehot(a));
      chk("fb_we_out", bus.fb_we_out, m_we);
      if (m_we) begin
        chk("fb_addr_out", bus.fb_addr_out, m_addr);
        chk("fb_data_out", bus.fb_data_out, m_addr & ((1 << CW) - 1));
      end
      if (m_rst) begin
        chk("reset_fb_addr", bus.fb_addr_out, 0);
        chk("reset_fb_data", bus.fb_data_out, 0);
      end
`ifdef RAY_SCHED_PERF_CNT_EN
      chk("frame_cycles_out", fcyc, m_perf);
`endif
    end
    if (bus.fb_we_out === 1'b1) wr_cnt[bus.fb_addr_out]++;
    if (done === 1'b1) done_cnt++;
    disp_cnt += $countones(bus.core_start_out);
    for (int i = 0; i < NC; i++) begin
      if (bus.core_ack_out[i]) c_job[i] = 0;
      if (bus.core_start_out[i]) begin
        c_job[i] = 1;
        c_col[i] = CW'(bus.core_vcount_out * H + bus.core_hcount_out);
        c_at[i] = cyc + (lat_fix[i] > 0 ? lat_fix[i] : int'($urandom_range(1, 5)));
      end
    end
    if (!rst_n) model_reset();
    else begin
      was_busy = m_busy;
      fin = m_busy && !m_disp && m_out == '0 && m_we;
      if (m_busy) busy_cyc++;
      m_we = a >= 0;
      if (a >= 0) begin
        m_addr = m_tag[a];
        m_cptr = (a + 1) % NC;
      end
      if (s >= 0) begin
        m_tag[s] = m_pix;
        m_pix++;
        if (m_pix == NPIX) m_disp = 0;
        m_dptr = (s + 1) % NC;
      end
      m_out = (m_out & ~onehot(a)) | onehot(s);
      m_done = fin;
      m_rst = 0;
      if (fin) begin
        m_busy = 0;
        m_perf = busy_cyc;
      end
      if (!was_busy && frame_start) begin
        m_busy = 1;
        m_disp = 1;
        m_pix = 0;
        busy_cyc = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NC; i++) begin
      bus.core_ready_in[i] = ready_en[i] && !c_job[i] && (!rnd_ready || $urandom_range(0, 3) != 0);
      bus.core_valid_in[i] = c_job[i] && cyc >= c_at[i];
      bus.core_color_in[i*CW +: CW] = c_col[i];
    end
  endtask
  task automatic run_frame(input int mid_start);
    int d0, n;
    d0 = done_cnt;
    foreach (wr_cnt[p]) wr_cnt[p] = 0;
    frame_start = 1;
    step();
    frame_start = 0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      frame_start = n == mid_start;
      step();
      n++;
    end
    frame_start = 0;
    chk("frame_completes", done_cnt != d0, 1);
    repeat (3) step();
    chk("done_pulse_count", done_cnt - d0, 1);
    for (int p = 0; p < NPIX; p++) chk("writes_per_addr", wr_cnt[p], 1);
  endtask
  initial begin
    int d0, x0, n;
    bus.core_ready_in = '0;
    bus.core_valid_in = '0;
    bus.core_color_in = '0;
    foreach (c_job[i]) begin
      c_job[i] = 0; c_at[i] = 0; c_col[i] = '0; lat_fix[i] = 3; ready_en[i] = 1;
    end
    m_ok = 0;
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    step();
    run_frame(-1);
    ready_en[1] = 0;
    run_frame(-1);
    ready_en[1] = 1;
    lat_fix[1] = 2;
    run_frame(-1);
    lat_fix[1] = 3;
    run_frame(4);
    d0 = done_cnt;
    x0 = disp_cnt;
    frame_start = 1;
    step();
    frame_start = 0;
    n = 0;
    while (disp_cnt - x0 < 3 && n < 50) begin
      step();
      n++;
    end
    chk("three_dispatches", disp_cnt - x0, 3);
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (4) step();
    chk("no_done_after_reset", done_cnt - d0, 0);
    foreach (c_job[i]) c_job[i] = 0;
    step();
    run_frame(-1);
    lat_fix = '{0, 0};
    rnd_ready = 1;
    repeat (6) run_frame(int'($urandom_range(0, 10)));
    rnd_ready = 0;
`ifdef RAY_SCHED_PERF_CNT_EN
    lat_fix = '{1, 1};
    run_frame(-1);
    chk("frame_cycles_nominal", fcyc, 10);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
